// File: rtl/register_file_multiport_if.sv
// Register file bus: read ports, two write-back ports, issue port and ready.
// The master side drives addresses, strobes and data; the slave side is the register file.
interface register_file_multiport_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
);
    logic                           ready;
    logic [NUM_READ*ADDR_WIDTH-1:0] read_register;
    logic [NUM_READ*DATA_WIDTH-1:0] read_data;
    logic [NUM_READ-1:0]            read_busy;
    logic                           write_enable_0;
    logic [ADDR_WIDTH-1:0]          write_register_0;
    logic [DATA_WIDTH-1:0]          write_data_0;
    logic                           write_enable_1;
    logic [ADDR_WIDTH-1:0]          write_register_1;
    logic [DATA_WIDTH-1:0]          write_data_1;
    logic                           issue_valid;
    logic [ADDR_WIDTH-1:0]          issue_register;

    modport master (
        output read_register, write_enable_0, write_register_0, write_data_0,
               write_enable_1, write_register_1, write_data_1,
               issue_valid, issue_register,
        input  ready, read_data, read_busy
    );

    modport slave (
        input  read_register, write_enable_0, write_register_0, write_data_0,
               write_enable_1, write_register_1, write_data_1,
               issue_valid, issue_register,
        output ready, read_data, read_busy
    );
endinterface

// File: rtl/register_file_multiport.sv
// Multiport register file with two write-back ports, a busy scoreboard and a
// sequential clear engine that zeroes one entry per cycle after reset.
// Entry 0 always reads zero and is never marked busy.
// Optional macro REGFILE_BYPASS_EN: same-cycle write data is forwarded to
// matching reads (WB1 over WB0); without it, writes are visible one cycle later.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | zeroing entry clear_index each cycle; outputs forced to 0
// ST_READY | normal operation: writes, scoreboard and reads active
module register_file_multiport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
) (
    input logic                      clock,
    input logic                      reset_n,
    register_file_multiport_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] clear_index;
    logic                  clearing;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_next;

    // State register; reset always restarts the clear sequence.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave CLEAR once the last entry is being zeroed.
    always_comb begin
        state_next = state;
        case (state)
            ST_CLEAR: if (clear_index == {ADDR_WIDTH{1'b1}}) state_next = ST_READY;
            ST_READY: state_next = ST_READY;
            default:  state_next = ST_CLEAR;
        endcase
    end

    // Outputs decoded from the state.
    always_comb begin
        clearing  = (state == ST_CLEAR);
        bus.ready = (state == ST_READY);
    end

    // Clear pointer walks the array once per clear sequence.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            clear_index <= '0;
        end else if (clearing) begin
            clear_index <= clear_index + 1'b1;
        end
    end

    // Array update: clear engine or write-back; WB1 is last so it wins a collision.
    // The reset edge itself leaves the array untouched.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            if (clearing) begin
                mem[clear_index] <= '0;
            end else begin
                if (bus.write_enable_0 && bus.write_register_0 != '0)
                    mem[bus.write_register_0] <= bus.write_data_0;
                if (bus.write_enable_1 && bus.write_register_1 != '0)
                    mem[bus.write_register_1] <= bus.write_data_1;
            end
        end
    end

    // Scoreboard next value: write-backs clear, issue sets afterwards so the newer producer wins.
    always_comb begin
        busy_next = busy;
        if (!clearing) begin
            if (bus.write_enable_0) busy_next[bus.write_register_0] = 1'b0;
            if (bus.write_enable_1) busy_next[bus.write_register_1] = 1'b0;
            if (bus.issue_valid)    busy_next[bus.issue_register]   = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] value;

        assign addr = bus.read_register[k*ADDR_WIDTH +: ADDR_WIDTH];

        // Resolve one read port: array value, optional forwarding, then zero overrides.
        always_comb begin
            value = mem[addr];
`ifdef REGFILE_BYPASS_EN
            if (bus.write_enable_1 && bus.write_register_1 == addr)
                value = bus.write_data_1;
            else if (bus.write_enable_0 && bus.write_register_0 == addr)
                value = bus.write_data_0;
`endif
            if (addr == '0 || clearing) value = '0;
        end

        assign bus.read_data[k*DATA_WIDTH +: DATA_WIDTH] = value;
        assign bus.read_busy[k] = clearing ? 1'b0 : busy[addr];
    end
endmodule

// File: tb/tb_register_file_multiport.sv
// Testbench for register_file_multiport: directed scenarios plus randomized
// traffic checked against an array-based reference model. A second instance
// covers the 64-bit / 16-entry / 3-port configuration.
module tb_register_file_multiport;
    logic clock;
    logic reset_n_a;
    logic reset_n_b;

    register_file_multiport_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) bus_a ();
    register_file_multiport_if #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .NUM_READ(3)) bus_b ();

    register_file_multiport #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) dut_a (
        .clock   (clock),
        .reset_n (reset_n_a),
        .bus     (bus_a)
    );

    register_file_multiport #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .NUM_READ(3)) dut_b (
        .clock   (clock),
        .reset_n (reset_n_b),
        .bus     (bus_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] ref_mem  [32];
    bit          ref_busy [32];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            ref_mem[i]  = '0;
            ref_busy[i] = 1'b0;
        end
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a,
                                             input bit we0, input logic [4:0] wr0, input logic [31:0] wd0,
                                             input bit we1, input logic [4:0] wr1, input logic [31:0] wd1);
        if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (we1 && wr1 == a) return wd1;
        if (we0 && wr0 == a) return wd0;
`endif
        return ref_mem[a];
    endfunction

    task automatic idle_a();
        bus_a.write_enable_0   = 1'b0;
        bus_a.write_register_0 = '0;
        bus_a.write_data_0     = '0;
        bus_a.write_enable_1   = 1'b0;
        bus_a.write_register_1 = '0;
        bus_a.write_data_1     = '0;
        bus_a.issue_valid      = 1'b0;
        bus_a.issue_register   = '0;
    endtask

    // One READY-state cycle on instance A: drive, check reads, clock, update model.
    task automatic cycle(input bit we0, input logic [4:0] wr0, input logic [31:0] wd0,
                         input bit we1, input logic [4:0] wr1, input logic [31:0] wd1,
                         input bit iv,  input logic [4:0] ir,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        @(negedge clock);
        bus_a.write_enable_0   = we0;
        bus_a.write_register_0 = wr0;
        bus_a.write_data_0     = wd0;
        bus_a.write_enable_1   = we1;
        bus_a.write_register_1 = wr1;
        bus_a.write_data_1     = wd1;
        bus_a.issue_valid      = iv;
        bus_a.issue_register   = ir;
        bus_a.read_register    = {ra1, ra0};
        #1;
        chk("ready", 64'(bus_a.ready), 64'd1);
        chk("rd0", 64'(bus_a.read_data[31:0]),  64'(exp_read(ra0, we0, wr0, wd0, we1, wr1, wd1)));
        chk("rd1", 64'(bus_a.read_data[63:32]), 64'(exp_read(ra1, we0, wr0, wd0, we1, wr1, wd1)));
        chk("busy0", 64'(bus_a.read_busy[0]), 64'(ref_busy[ra0]));
        chk("busy1", 64'(bus_a.read_busy[1]), 64'(ref_busy[ra1]));
        @(posedge clock);
        if (we0 && wr0 != 5'd0) ref_mem[wr0] = wd0;
        if (we1 && wr1 != 5'd0) ref_mem[wr1] = wd1;
        if (we0) ref_busy[wr0] = 1'b0;
        if (we1) ref_busy[wr1] = 1'b0;
        if (iv && ir != 5'd0) ref_busy[ir] = 1'b1;
        #1;
        idle_a();
    endtask

    task automatic rd(input logic [4:0] ra0, input logic [4:0] ra1);
        cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, ra0, ra1);
    endtask

    task automatic pulse_reset_a();
        @(negedge clock);
        reset_n_a = 1'b0;
        @(negedge clock);
        reset_n_a = 1'b1;
    endtask

    // Count cycles until ready, checking outputs stay zero meanwhile; bounded.
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (bus_a.ready !== 1'b1 && cnt < 100) begin
            chk("clear_rd", 64'(bus_a.read_data[31:0]), 64'd0);
            chk("clear_busy", 64'(bus_a.read_busy), 64'd0);
            @(posedge clock);
            #1;
            cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        logic [4:0] wr0, wr1, ra0, ra1, ir;

        reset_n_a = 1'b0;
        reset_n_b = 1'b0;
        idle_a();
        bus_a.read_register    = '0;
        bus_b.read_register    = '0;
        bus_b.write_enable_0   = 1'b0;
        bus_b.write_register_0 = '0;
        bus_b.write_data_0     = '0;
        bus_b.write_enable_1   = 1'b0;
        bus_b.write_register_1 = '0;
        bus_b.write_data_1     = '0;
        bus_b.issue_valid      = 1'b0;
        bus_b.issue_register   = '0;

        // Initial clear
        repeat (2) @(posedge clock);
        #1;
        chk("reset_ready", 64'(bus_a.ready), 64'd0);
        pulse_reset_a();
        #1;
        wait_ready(cnt);
        chk("init_clear_cycles", 64'(cnt), 64'd32);
        model_clear();

        // Clear sequence after preload, with writes/issues attempted during CLEAR
        cycle(1, 5'd7, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0, 5'd0, 5'd7, 5'd0);
        rd(5'd7, 5'd5);
        @(negedge clock);
        reset_n_a = 1'b0;
        @(negedge clock);
        reset_n_a = 1'b1;
        bus_a.write_enable_0   = 1'b1;
        bus_a.write_register_0 = 5'd5;
        bus_a.write_data_0     = 32'h5555_5555;
        bus_a.write_enable_1   = 1'b1;
        bus_a.write_register_1 = 5'd7;
        bus_a.write_data_1     = 32'h7777_7777;
        bus_a.issue_valid      = 1'b1;
        bus_a.issue_register   = 5'd5;
        bus_a.read_register    = {5'd5, 5'd7};
        #1;
        chk("clear_ready_low", 64'(bus_a.ready), 64'd0);
        wait_ready(cnt);
        idle_a();
        chk("clear_cycles", 64'(cnt), 64'd32);
        model_clear();
        rd(5'd7, 5'd5);

        // Dual write collision and writes to r0
        cycle(1, 5'd3, 32'h11111111, 1, 5'd3, 32'h22222222, 0, 5'd0, 5'd3, 5'd0);
        rd(5'd3, 5'd3);
        chk("collision_r3", 64'(bus_a.read_data[31:0]), 64'h22222222);
        cycle(1, 5'd0, 32'h11111111, 1, 5'd0, 32'h22222222, 0, 5'd0, 5'd0, 5'd0);
        rd(5'd0, 5'd3);

        // Bypass / write-to-read latency
        cycle(1, 5'd9, 32'h0BADF00D, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd9);
        cycle(1, 5'd9, 32'hCAFEF00D, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd9);
        rd(5'd0, 5'd9);
        chk("bypass_next_cycle", 64'(bus_a.read_data[63:32]), 64'hCAFEF00D);
        cycle(1, 5'd9, 32'h1234_5678, 1, 5'd9, 32'h8765_4321, 0, 5'd0, 5'd9, 5'd9);

        // Scoreboard
        cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd4, 5'd4, 5'd0);
        rd(5'd4, 5'd4);
        chk("busy_after_issue", 64'(bus_a.read_busy[0]), 64'd1);
        cycle(1, 5'd4, 32'h44, 0, 5'd0, 32'd0, 0, 5'd0, 5'd4, 5'd0);
        rd(5'd4, 5'd0);
        chk("busy_after_wb", 64'(bus_a.read_busy[0]), 64'd0);
        cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd4, 5'd4, 5'd0);
        cycle(0, 5'd0, 32'd0, 1, 5'd4, 32'h45, 1, 5'd4, 5'd4, 5'd0);
        rd(5'd4, 5'd0);
        chk("busy_set_wins", 64'(bus_a.read_busy[0]), 64'd1);
        cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd0, 5'd0, 5'd0);
        rd(5'd0, 5'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            wr0 = 5'($urandom_range(0, 31));
            wr1 = ($urandom_range(0, 3) == 0) ? wr0 : 5'($urandom_range(0, 31));
            ir  = ($urandom_range(0, 3) == 0) ? wr1 : 5'($urandom_range(0, 31));
            case ($urandom_range(0, 2))
                0:       ra0 = wr0;
                1:       ra0 = wr1;
                default: ra0 = 5'($urandom_range(0, 31));
            endcase
            ra1 = ($urandom_range(0, 1) == 0) ? ir : 5'($urandom_range(0, 31));
            cycle(1'($urandom_range(0, 1)), wr0, $urandom,
                  1'($urandom_range(0, 1)), wr1, $urandom,
                  1'($urandom_range(0, 1)), ir, ra0, ra1);
        end

        // Reset in the middle of a clear
        cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd10, 5'd10, 5'd0);
        cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd20, 5'd20, 5'd10);
        pulse_reset_a();
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            chk("midclear_ready", 64'(bus_a.ready), 64'd0);
        end
        pulse_reset_a();
        #1;
        wait_ready(cnt);
        chk("midclear_cycles", 64'(cnt), 64'd32);
        model_clear();
        for (int a = 0; a < 32; a += 2) rd(5'(a), 5'(a + 1));

        // Wide/narrow parameter set on instance B
        @(negedge clock);
        reset_n_b = 1'b0;
        @(negedge clock);
        reset_n_b = 1'b1;
        #1;
        cnt = 0;
        while (bus_b.ready !== 1'b1 && cnt < 100) begin
            @(posedge clock);
            #1;
            cnt++;
        end
        chk("b_clear_cycles", 64'(cnt), 64'd16);
        @(negedge clock);
        bus_b.write_enable_0   = 1'b1;
        bus_b.write_register_0 = 4'd15;
        bus_b.write_data_0     = 64'h0123456789ABCDEF;
        bus_b.read_register    = {4'd15, 4'd15, 4'd15};
        @(posedge clock);
        #1;
        bus_b.write_enable_0 = 1'b0;
        #1;
        chk("b_rd0", bus_b.read_data[63:0],    64'h0123456789ABCDEF);
        chk("b_rd1", bus_b.read_data[127:64],  64'h0123456789ABCDEF);
        chk("b_rd2", bus_b.read_data[191:128], 64'h0123456789ABCDEF);
        chk("b_busy", 64'(bus_b.read_busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/register_file_multiport.md
Name: register_file_multiport

Overview:
Parametrised successor to the core's 2-read/1-write register file for the pipelined RISC-V datapath. It provides:
- NUM_READ combinational read ports.
- Two write-back ports: WB0 for ALU results, WB1 for load results.
- A per-register busy scoreboard, so the hazard unit can stall on pending producers.
- A sequential clear engine that zeroes the array one entry per cycle after reset, replacing the single-cycle reset loop.
- Entry 0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, bits per register.
- ADDR_WIDTH, 5, register index width; DEPTH = 2**ADDR_WIDTH.
- NUM_READ, 2, number of read ports (1..4).

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- ready  output  1  high once the clear sequence completes.
- read_register  input  NUM_READ*ADDR_WIDTH  flattened read addresses; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- read_data  output  NUM_READ*DATA_WIDTH  flattened read data.
- read_busy  output  NUM_READ  busy bit for each read address.
- write_enable_0  input  1  WB0 write strobe.
- write_register_0  input  ADDR_WIDTH  WB0 address.
- write_data_0  input  DATA_WIDTH  WB0 data.
- write_enable_1  input  1  WB1 write strobe.
- write_register_1  input  ADDR_WIDTH  WB1 address.
- write_data_1  input  DATA_WIDTH  WB1 data.
- issue_valid  input  1  an instruction with a destination issues this cycle.
- issue_register  input  ADDR_WIDTH  destination of the issuing instruction.

Behaviour:
- Reset: clock and reset are one clock and a synchronous active-low reset, named clock and reset_n.
  - On a clock edge with reset_n=0: state<=CLEAR, clear_index<=0, all busy bits<=0, ready<=0.
  - Array contents are not touched by reset itself.
- CLEAR state:
  - Each cycle: register[clear_index]<=0 and clear_index++.
  - When clear_index==DEPTH-1, that final entry is zeroed and state<=READY.
  - Duration: exactly DEPTH cycles from reset release to ready=1.
  - write_enable_*, issue_valid and writeback clears are ignored.
  - read_data=0 and read_busy=0 on all ports.
- Reset asserted mid-CLEAR or in READY: the clear restarts from index 0.
- READY state: ready=1 and remains there until reset_n=0.
- Writes (READY only):
  - Synchronous on the rising edge.
  - A write to address 0 is discarded.
  - Both ports to the same nonzero address in one cycle: WB1 wins.
  - Different addresses: both are written.
- Reads:
  - Combinational; address 0 always returns 0.
  - Any other address returns the array value, subject to the bypass rule under Optional Feature.
- Scoreboard, one busy bit per entry; bit 0 is constant 0:
  - issue_valid with nonzero issue_register sets busy[issue_register] at the edge.
  - An enabled write on either port clears busy[write address] at the edge.
  - Set and clear of the same register in the same cycle: the set wins, because the newer producer is pending.
  - read_busy[k] = busy[read address k], combinational. It reflects the pre-edge state and is not bypassed.
- Width rules:
  - No sign or width conversion.
  - Unused high bits of the flattened buses are not allowed; widths are exact.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read whose nonzero address matches an enabled same-cycle write returns that write's data combinationally, with WB1 taking priority over WB0.
  - Write-to-read latency is 0 cycles.
- Undefined:
  - Reads return the stored value only.
  - A write becomes visible on the cycle after the edge, so write-to-read latency is 1 cycle.
- In both cases, the bypass is inactive during CLEAR.

Test Plan:
1. Clear sequence. Preload r7=0xDEADBEEF, pulse reset_n=0 for 1 cycle. Required: ready=0 for exactly 32 cycles, then 1; read r7 = 0x00000000; write attempts during CLEAR leave r5 = 0.
2. Dual write collision. WB0 writes r3=0x11111111 and WB1 writes r3=0x22222222 in the same cycle. Required: next-cycle read r3 = 0x22222222. Same stimulus to r0: r0 reads 0.
3. Bypass. With REGFILE_BYPASS_EN, WB0 writes r9=0xCAFEF00D while port 1 reads r9. Required: same-cycle read_data = 0xCAFEF00D. Without the macro: the old value that cycle, 0xCAFEF00D the next cycle.
4. Scoreboard. Issue r4, then read r4. Required: read_busy=1 from the next cycle onward. WB0 writes r4: busy=0 the following cycle. Issue r4 in the same cycle as a write to r4: busy stays 1.
5. Reset mid-clear. Assert reset_n=0 at clear cycle 10, release. Required: ready is low for a further full 32 cycles and all busy bits are 0.
6. Parameter sweep. DATA_WIDTH=64, ADDR_WIDTH=4, NUM_READ=3. Write r15=0x0123456789ABCDEF. Required: all three ports reading r15 return the value; ready after 16 cycles.
